// File: rtl/zxw_pkg.sv
// Shared constants and types for the switch conditioner.
`default_nettype none

package zxw_pkg;

  localparam int SW_WIDTH            = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_CYCLES   = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } evt_state_t;

  // One extra bit above clog2 so the counter can saturate instead of wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zxw_debounce_bit.sv
// One switch bit: two-flop synchronizer, saturating debounce counter, level and rise pulse.
// Auto-repeat of the rise pulse is present only when ZXW_SW_AUTOREPEAT_EN is defined.
`default_nettype none

module zxw_debounce_bit
  import zxw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef ZXW_SW_AUTOREPEAT_EN
  , parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic update,
  output logic next_level
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          repeat_hit;

  assign update     = (s2 != level) && (cnt == CNT_LAST);
  assign next_level = update ? s2 : level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (update) begin
        level <= s2;
        cnt   <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef ZXW_SW_AUTOREPEAT_EN
  localparam int            RW     = cnt_width(REPEAT_CYCLES);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt;

  // Restarted on the accepting edge so the first repeat lands REPEAT_CYCLES after the initial pulse.
  assign repeat_hit = level && !update && (rcnt == R_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (!level || update || repeat_hit) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
    end else begin
      rise <= (update && s2) || repeat_hit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/zxw_switch_conditioner.sv
// Switch bank front-end: per-bit debounce plus a latched change event with valid/ack and overrun.
// Optional auto-repeat of SW_rise is enabled by defining ZXW_SW_AUTOREPEAT_EN.
`default_nettype none

module zxw_switch_conditioner
  import zxw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW_out,
  output logic [WIDTH-1:0] SW_rise,
  output logic             Event_valid,
  output logic [WIDTH-1:0] Event_data,
  output logic [WIDTH-1:0] Event_mask,
  input  logic             Event_ack,
  output logic             Overrun
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("zxw_switch_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] next_sw;
  evt_state_t       state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    zxw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef ZXW_SW_AUTOREPEAT_EN
      , .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
    ) u_bit (
      .clk        (Clock),
      .rst_n      (Resetn),
      .raw        (SW_raw[i]),
      .level      (SW_out[i]),
      .rise       (SW_rise[i]),
      .update     (chg[i]),
      .next_level (next_sw[i])
    );
  end

  // Event capture uses next_sw so Event_data matches SW_out as of the accepting edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      Event_valid <= 1'b0;
      Event_data  <= '0;
      Event_mask  <= '0;
      Overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (chg != '0) begin
            state       <= PENDING;
            Event_valid <= 1'b1;
            Event_data  <= next_sw;
            Event_mask  <= chg;
          end
        end
        PENDING: begin
          if (Event_ack) begin
            if (chg == '0) begin
              state       <= IDLE;
              Event_valid <= 1'b0;
              Event_mask  <= '0;
              Overrun     <= 1'b0;
            end else begin
              Event_data <= next_sw;
              Event_mask <= chg;
            end
          end else if (chg != '0) begin
            Event_data <= next_sw;
            Event_mask <= Event_mask | chg;
            Overrun    <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          Event_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zxw_switch_conditioner.sv
// Scoreboard bench: every output-tuple change is matched against a queued expectation.
`default_nettype none

module tb_zxw_switch_conditioner;

  logic       Clock;
  logic       Resetn;
  logic [4:0] SW_raw;
  logic [4:0] SW_out;
  logic [4:0] SW_rise;
  logic       Event_valid;
  logic [4:0] Event_data;
  logic [4:0] Event_mask;
  logic       Event_ack;
  logic       Overrun;

  zxw_switch_conditioner dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .SW_raw      (SW_raw),
    .SW_out      (SW_out),
    .SW_rise     (SW_rise),
    .Event_valid (Event_valid),
    .Event_data  (Event_data),
    .Event_mask  (Event_mask),
    .Event_ack   (Event_ack),
    .Overrun     (Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Tuple layout: {SW_out, SW_rise, Event_valid, Event_data, Event_mask, Overrun}
  function automatic logic [21:0] pack(input logic [4:0] o, input logic [4:0] r, input logic v,
                                       input logic [4:0] d, input logic [4:0] m, input logic ov);
    return {o, r, v, d, m, ov};
  endfunction

  typedef struct {
    string       tag;
    int          at;
    logic [21:0] val;
  } exp_t;

  exp_t        q[$];
  logic        mon_en = 1'b0;
  logic [21:0] prev   = '0;

  task automatic expect_at(input string tag, input int at, input logic [4:0] o, input logic [4:0] r,
                           input logic v, input logic [4:0] d, input logic [4:0] m, input logic ov);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.val = pack(o, r, v, d, m, ov);
    q.push_back(e);
  endtask

  always @(negedge Clock) begin
    logic [21:0] cur;
    exp_t        e;
    cur = pack(SW_out, SW_rise, Event_valid, Event_data, Event_mask, Overrun);
    if (mon_en && cur != prev) begin
      if (q.size() == 0) begin
        check("spurious_change", {10'd0, cur}, {10'd0, prev});
      end else begin
        e = q.pop_front();
        check({e.tag, "_cycle"}, cyc, e.at);
        check(e.tag, {10'd0, cur}, {10'd0, e.val});
      end
    end
    prev = cur;
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge Clock);
  endtask

  initial begin
    int c;
    int d;
    Resetn    = 1'b1;
    SW_raw    = 5'b00000;
    Event_ack = 1'b0;
    #2;
    Resetn = 1'b0;
    SW_raw = 5'b10101;
    repeat (4) @(negedge Clock);
    check("rst_sw_out", {27'd0, SW_out}, 32'd0);
    check("rst_sw_rise", {27'd0, SW_rise}, 32'd0);
    check("rst_valid", {31'd0, Event_valid}, 32'd0);
    check("rst_data", {27'd0, Event_data}, 32'd0);
    check("rst_mask", {27'd0, Event_mask}, 32'd0);
    check("rst_overrun", {31'd0, Overrun}, 32'd0);
    SW_raw = 5'b00000;
    @(negedge Clock);
    Resetn = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge Clock);

    // Reset in the middle of a debounce count; the count must restart after release.
    c = cyc;
    SW_raw = 5'b00001;
    wait_to(c + 4);
    Resetn = 1'b0;
    #1;
    check("mid_reset_sw_out", {27'd0, SW_out}, 32'd0);
    wait_to(c + 6);
    Resetn = 1'b1;
    c = cyc;
    expect_at("press", c + 6, 5'b00001, 5'b00001, 1'b1, 5'b00001, 5'b00001, 1'b0);
    expect_at("press_rise_end", c + 7, 5'b00001, 5'b00000, 1'b1, 5'b00001, 5'b00001, 1'b0);
    wait_to(c + 10);

    // Handshake with no concurrent change.
    c = cyc;
    Event_ack = 1'b1;
    expect_at("ack_press", c + 1, 5'b00001, 5'b00000, 1'b0, 5'b00001, 5'b00000, 1'b0);
    wait_to(c + 1);
    Event_ack = 1'b0;
    wait_to(c + 3);

    // Ack while idle must be ignored.
    c = cyc;
    Event_ack = 1'b1;
    wait_to(c + 2);
    Event_ack = 1'b0;
    wait_to(c + 4);

    // Bounce on bit 2 in 2-cycle segments, then hold.
    c = cyc;
    SW_raw = 5'b00101;
    wait_to(c + 2);
    SW_raw = 5'b00001;
    wait_to(c + 4);
    SW_raw = 5'b00101;
    expect_at("bounce", c + 10, 5'b00101, 5'b00100, 1'b1, 5'b00101, 5'b00100, 1'b0);
    expect_at("bounce_rise_end", c + 11, 5'b00101, 5'b00000, 1'b1, 5'b00101, 5'b00100, 1'b0);
    wait_to(c + 12);
    c = cyc;
    Event_ack = 1'b1;
    expect_at("ack_bounce", c + 1, 5'b00101, 5'b00000, 1'b0, 5'b00101, 5'b00000, 1'b0);
    wait_to(c + 1);
    Event_ack = 1'b0;
    wait_to(c + 3);

    // Overrun: bit 0 falls (no rise pulse), then bit 3 settles before any ack.
    c = cyc;
    SW_raw = 5'b00100;
    expect_at("fall_bit0", c + 6, 5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00001, 1'b0);
    wait_to(c + 6);
    SW_raw = 5'b01100;
    expect_at("overrun", c + 12, 5'b01100, 5'b01000, 1'b1, 5'b01100, 5'b01001, 1'b1);
    expect_at("overrun_rise_end", c + 13, 5'b01100, 5'b00000, 1'b1, 5'b01100, 5'b01001, 1'b1);
    wait_to(c + 17);
    c = cyc;
    Event_ack = 1'b1;
    expect_at("ack_overrun", c + 1, 5'b01100, 5'b00000, 1'b0, 5'b01100, 5'b00000, 1'b0);
    wait_to(c + 1);
    Event_ack = 1'b0;
    wait_to(c + 3);

    // Build an overrun, then ack on the same edge bit 1 settles.
    c = cyc;
    SW_raw = 5'b01101;
    expect_at("press_bit0", c + 6, 5'b01101, 5'b00001, 1'b1, 5'b01101, 5'b00001, 1'b0);
    expect_at("press_bit0_rise_end", c + 7, 5'b01101, 5'b00000, 1'b1, 5'b01101, 5'b00001, 1'b0);
    wait_to(c + 6);
    SW_raw = 5'b11101;
    expect_at("press_bit4", c + 12, 5'b11101, 5'b10000, 1'b1, 5'b11101, 5'b10001, 1'b1);
    expect_at("press_bit4_rise_end", c + 13, 5'b11101, 5'b00000, 1'b1, 5'b11101, 5'b10001, 1'b1);
    wait_to(c + 13);
    d = cyc;
    SW_raw = 5'b11111;
    expect_at("ack_with_change", d + 6, 5'b11111, 5'b00010, 1'b1, 5'b11111, 5'b00010, 1'b1);
    expect_at("ack_with_change_rise_end", d + 7, 5'b11111, 5'b00000, 1'b1, 5'b11111, 5'b00010, 1'b1);
    wait_to(d + 5);
    Event_ack = 1'b1;
    wait_to(d + 6);
    Event_ack = 1'b0;
    wait_to(d + 8);
    c = cyc;
    Event_ack = 1'b1;
    expect_at("ack_clear", c + 1, 5'b11111, 5'b00000, 1'b0, 5'b11111, 5'b00000, 1'b0);
    wait_to(c + 1);
    Event_ack = 1'b0;
    wait_to(c + 3);

    // All bits fall on one edge: one event, full mask, no rise pulses.
    c = cyc;
    SW_raw = 5'b00000;
    expect_at("all_fall", c + 6, 5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b11111, 1'b0);
    wait_to(c + 8);
    c = cyc;
    Event_ack = 1'b1;
    expect_at("ack_all_fall", c + 1, 5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 1'b0);
    wait_to(c + 1);
    Event_ack = 1'b0;
    wait_to(c + 6);

    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
